layer_2_fm_sequencer: RTL and testbench
=======================================

Name: layer_2_fm_sequencer

Overview:
- Sequences one convolutional layer that is built from per-output-channel featuremap units (Conv2D3x3 banks, 16 input channels packed 32 bits each).
- For each output featuremap in turn, it streams the whole input image from the layer input buffer into the selected featuremap unit, counts that unit's output pixels, then advances to the next featuremap.
- It sits between the layer input buffer, the featuremap bank, and the layer top-level control.

Parameters:
IMG_SIZE, 208, input image width and height in pixels
NUM_FM, 32, number of output featuremaps to sequence
OUT_PIXELS, IMG_SIZE*IMG_SIZE, valid_out pulses expected per featuremap
RD_LATENCY, 1, input-buffer read latency in cycles (≥1)
ADDR_WIDTH, $clog2(IMG_SIZE*IMG_SIZE), read address width
FM_WIDTH, $clog2(NUM_FM), featuremap index width

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to run the whole layer
hold  in  1  stall pixel issue (downstream not ready); sampled each cycle
rd_en  out  1  input-buffer read strobe
rd_addr  out  ADDR_WIDTH  input-buffer read address (raster order)
fm_valid_in  out  1  valid_in to featuremap bank; rd_en delayed RD_LATENCY cycles
fm_sel  out  FM_WIDTH  index of the active featuremap unit
fm_start  out  1  one-cycle pulse that clears the selected unit's line buffers before its first pixel
fm_valid_out  in  1  valid_out from the selected featuremap unit
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last featuremap completes
err  out  1  sticky; set on unexpected fm_valid_out; cleared only by Rst

Behaviour:
- Synchronous active-high reset, single clock Clk.
- Reset values: state=IDLE; rd_en, rd_addr, fm_valid_in, fm_sel, fm_start, busy, done and err are all 0; pixel counter, output counter and latency shift register are cleared.
- States: IDLE, START, FEED, DRAIN, NEXT, FIN.
- IDLE:
  - start=1 → START next cycle; busy=1 from that cycle.
  - start in any other state is ignored.
- START (1 cycle):
  - fm_start=1; pix_cnt=0; out_cnt=0 → FEED.
- FEED:
  - Each cycle with hold=0: rd_en=1, rd_addr=pix_cnt, pix_cnt++.
  - Each cycle with hold=1: rd_en=0 and the address holds.
  - When rd_en is issued with pix_cnt=IMG_SIZE²-1 → DRAIN next cycle; rd_addr returns to 0.
  - rd_en and rd_addr are registered, so first rd_en is the cycle after START.
- fm_valid_in:
  - fm_valid_in = rd_en shifted through a RD_LATENCY-deep register chain.
  - The chain runs regardless of state and is cleared only by Rst.
- Output counting:
  - out_cnt increments on every fm_valid_out in FEED or DRAIN.
  - This covers output that overlaps input, since the conv pipeline emits while being fed.
- DRAIN:
  - Waits until out_cnt reaches OUT_PIXELS (including an increment in the current cycle) → NEXT.
  - No timeout.
- NEXT (1 cycle):
  - If fm_sel=NUM_FM-1 → FIN.
  - Else fm_sel++ → START.
- FIN (1 cycle):
  - done=1 → IDLE.
  - busy drops to 0 in the IDLE cycle; fm_sel returns to 0 on entry to IDLE.
- err is set (sticky) in any of these cases:
  - fm_valid_out=1 while in IDLE, START, NEXT or FIN;
  - out_cnt would exceed OUT_PIXELS.
  - The extra pulse is not counted.
- Simultaneous events:
  - hold=1 on the final FEED pixel delays the DRAIN transition until the pixel is issued.
  - fm_valid_out in the same cycle as the FEED→DRAIN transition is counted.
- Reset mid-operation: Rst in any state returns all outputs to their reset values on the next edge, including clearing err. Pending valid in the latency chain is discarded.
- Counter widths: pix_cnt is ADDR_WIDTH+1 bits and out_cnt is $clog2(OUT_PIXELS+1) bits, so neither wraps. Comparisons use exact equality.
- Total layer latency (no hold, no overlap): NUM_FM × (1 + IMG_SIZE² + drain + 1) + 1 cycles.

Test Plan (IMG_SIZE=4, NUM_FM=2, OUT_PIXELS=16, RD_LATENCY=2 unless noted):
- Reset then idle → all outputs 0 for 10 cycles; start pulse → fm_start=1 one cycle later, rd_en high for 16 consecutive cycles with rd_addr 0..15, fm_valid_in the same pattern delayed 2 cycles.
- Model echoes fm_valid_in as fm_valid_out after 5 cycles → fm_sel 0 then 1, two fm_start pulses, done a single pulse, busy low the cycle after done, err=0.
- hold=1 for 3 cycles at rd_addr=7 and on the final pixel → address sequence still 0..15 without gaps or repeats, rd_en low exactly during hold, DRAIN entered only after addr 15 is issued.
- Extra fm_valid_out pulse while IDLE → err=1 and stays 1 through a subsequent full run; Rst → err=0.
- Rst asserted mid-FEED (rd_addr=9, fm_sel=1) → next cycle state IDLE, rd_en=0, fm_sel=0, busy=0, no fm_valid_in pulses afterwards; new start reruns from fm_sel=0, addr 0.
- start asserted repeatedly while busy → ignored; exactly one done per accepted start, featuremap order unchanged.

Source files
------------

// File: rtl/layer_2_fm_sequencer.sv
// Runs one conv layer: for each output featuremap, streams the full input image
// into the selected featuremap unit and counts its output pixels before advancing.
`timescale 1ns/1ps
module layer_2_fm_sequencer #(
  parameter int IMG_SIZE   = 208,
  parameter int NUM_FM     = 32,
  parameter int OUT_PIXELS = IMG_SIZE * IMG_SIZE,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WIDTH = $clog2(IMG_SIZE * IMG_SIZE),
  parameter int FM_WIDTH   = $clog2(NUM_FM)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  fm_valid_in,
  output logic [FM_WIDTH-1:0]   fm_sel,
  output logic                  fm_start,
  input  logic                  fm_valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int OUT_CNT_W = $clog2(OUT_PIXELS + 1);
  localparam logic [ADDR_WIDTH:0]  PIX_TOTAL = (ADDR_WIDTH + 1)'(IMG_SIZE * IMG_SIZE);
  localparam logic [ADDR_WIDTH:0]  PIX_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [OUT_CNT_W-1:0] OUT_FULL  = OUT_CNT_W'(OUT_PIXELS);
  localparam logic [OUT_CNT_W-1:0] OUT_LAST  = OUT_CNT_W'(OUT_PIXELS - 1);
  localparam logic [OUT_CNT_W-1:0] OUT_ONE   = OUT_CNT_W'(1);
  localparam logic [FM_WIDTH-1:0]  FM_LAST   = FM_WIDTH'(NUM_FM - 1);
  localparam logic [FM_WIDTH-1:0]  FM_ONE    = FM_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, FEED, DRAIN, NEXT, FIN} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH:0]   pix_cnt_reg;
  logic [OUT_CNT_W-1:0]  out_cnt_reg;
  logic [RD_LATENCY-1:0] vld_pipe_reg;
  logic                  counting;
  logic                  out_full;
  logic                  unexpected;

  assign counting    = (state_reg == FEED) || (state_reg == DRAIN);
  assign out_full    = (out_cnt_reg == OUT_FULL);
  assign unexpected  = fm_valid_out && (!counting || out_full);
  assign fm_valid_in = vld_pipe_reg[RD_LATENCY-1];

  // Read-data valid follows rd_en by the buffer latency; runs in every state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_pipe_reg <= '0;
    end else begin
      vld_pipe_reg <= RD_LATENCY'({vld_pipe_reg, rd_en});
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= IDLE;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      fm_sel      <= '0;
      fm_start    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      pix_cnt_reg <= '0;
      out_cnt_reg <= '0;
    end else begin
      fm_start <= 1'b0;
      done     <= 1'b0;
      if (unexpected) begin
        err <= 1'b1;
      end
      if (counting && fm_valid_out && !out_full) begin
        out_cnt_reg <= out_cnt_reg + OUT_ONE;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= START;
            busy        <= 1'b1;
            fm_start    <= 1'b1;
            pix_cnt_reg <= '0;
            out_cnt_reg <= '0;
          end
        end
        // Issue decisions start in START so the first rd_en lands in the first FEED cycle.
        START, FEED: begin
          if (state_reg == FEED && pix_cnt_reg == PIX_TOTAL) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            state_reg <= DRAIN;
          end else begin
            state_reg <= FEED;
            rd_en     <= !hold;
            if (!hold) begin
              rd_addr     <= pix_cnt_reg[ADDR_WIDTH-1:0];
              pix_cnt_reg <= pix_cnt_reg + PIX_ONE;
            end
          end
        end
        DRAIN: begin
          if (out_full || (fm_valid_out && out_cnt_reg == OUT_LAST)) begin
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          if (fm_sel == FM_LAST) begin
            state_reg <= FIN;
            done      <= 1'b1;
          end else begin
            fm_sel      <= fm_sel + FM_ONE;
            state_reg   <= START;
            fm_start    <= 1'b1;
            pix_cnt_reg <= '0;
            out_cnt_reg <= '0;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          fm_sel    <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_2_fm_sequencer.sv
// Directed bench for layer_2_fm_sequencer (4x4 image, 2 featuremaps, read latency 2).
`timescale 1ns/1ps
module tb_layer_2_fm_sequencer;
  localparam int IMG_SIZE   = 4;
  localparam int NUM_FM     = 2;
  localparam int OUT_PIXELS = 16;
  localparam int RD_LATENCY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       hold;
  logic       fm_valid_out;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       fm_valid_in;
  logic [0:0] fm_sel;
  logic       fm_start;
  logic       busy;
  logic       done;
  logic       err;

  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         echo_en;
  logic [5:0] echo_hist;

  always #5 clk = ~clk;

  layer_2_fm_sequencer #(
    .IMG_SIZE(IMG_SIZE), .NUM_FM(NUM_FM), .OUT_PIXELS(OUT_PIXELS),
    .RD_LATENCY(RD_LATENCY), .ADDR_WIDTH(4), .FM_WIDTH(1)
  ) dut (
    .Clk(clk), .Rst(rst), .start(start), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .fm_valid_in(fm_valid_in),
    .fm_sel(fm_sel), .fm_start(fm_start), .fm_valid_out(fm_valid_out),
    .busy(busy), .done(done), .err(err)
  );

  // Advance one cycle; the featuremap model echoes fm_valid_in 5 cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    echo_hist = {echo_hist[4:0], fm_valid_in};
    if (echo_en) fm_valid_out = echo_hist[5];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; fm_valid_out = 1'b0;
    echo_en = 1'b0; echo_hist = '0;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if ({rd_en, rd_addr, fm_valid_in, fm_sel, fm_start, busy, done, err} !== 11'h0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%b exp=0", k,
                 {rd_en, rd_addr, fm_valid_in, fm_sel, fm_start, busy, done, err});
      end
    end
    echo_en = 1'b1;
  endtask

  // Whole layer, no hold: START at k=1 and k=26, reads k=2..17 and 27..42, done at k=51.
  task automatic test_full_run(input string name, input logic exp_err, input bit spam);
    logic       e_rd [0:63];
    logic       e_vi;
    logic [3:0] e_addr;
    logic [6:0] got;
    logic [6:0] exp;
    for (int k = 0; k < 64; k++) e_rd[k] = (k >= 2 && k <= 17) || (k >= 27 && k <= 42);
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      start  = (spam && k <= 51) ? 1'b1 : 1'b0;
      e_vi   = (k >= 2) ? e_rd[k-2] : 1'b0;
      e_addr = (k >= 27) ? 4'(k - 27) : 4'(k - 2);
      got = {rd_en, fm_valid_in, fm_start, fm_sel[0], busy, done, err};
      exp = {e_rd[k], e_vi, (k == 1 || k == 26), (k >= 26 && k <= 51), (k <= 51), (k == 51), exp_err};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s ctl k=%0d got=%b exp=%b (rd_en,vld_in,fm_start,fm_sel,busy,done,err)",
                 name, k, got, exp);
      end
      if (e_rd[k]) begin
        n_cmp++;
        if (rd_addr !== e_addr) begin
          n_fail++;
          $display("FAIL %s addr k=%0d got=%0d exp=%0d", name, k, rd_addr, e_addr);
        end
      end
    end
    start = 1'b0;
  endtask

  // Hold at addr 7 (3 cycles) and before the last pixel; each hold cycle blanks the next rd_en.
  task automatic test_hold();
    logic       e_rd [0:63];
    logic       e_vi;
    logic [3:0] e_addr;
    logic [5:0] got;
    logic [5:0] exp;
    for (int k = 0; k < 64; k++)
      e_rd[k] = (k >= 2 && k <= 9) || (k >= 13 && k <= 19) || (k == 21) || (k >= 31 && k <= 46);
    start = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      tick();
      start = 1'b0;
      hold  = (k == 9 || k == 10 || k == 11 || k == 19) ? 1'b1 : 1'b0;
      e_vi  = (k >= 2) ? e_rd[k-2] : 1'b0;
      if (k <= 9)       e_addr = 4'(k - 2);
      else if (k <= 12) e_addr = 4'd7;
      else if (k <= 19) e_addr = 4'(k - 5);
      else if (k == 20) e_addr = 4'd14;
      else if (k == 21) e_addr = 4'd15;
      else              e_addr = 4'(k - 31);
      got = {rd_en, fm_valid_in, fm_start, busy, done, err};
      exp = {e_rd[k], e_vi, (k == 1 || k == 30), (k <= 55), (k == 55), 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold ctl k=%0d got=%b exp=%b (rd_en,vld_in,fm_start,busy,done,err)", k, got, exp);
      end
      if ((k >= 2 && k <= 21) || (k >= 31 && k <= 46)) begin
        n_cmp++;
        if (rd_addr !== e_addr) begin
          n_fail++;
          $display("FAIL hold addr k=%0d got=%0d exp=%0d", k, rd_addr, e_addr);
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_err_idle();
    echo_en = 1'b0;
    fm_valid_out = 1'b1;
    tick();
    fm_valid_out = 1'b0;
    n_cmp++;
    if ({err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_set got err,busy=%b exp=10", {err, busy});
    end
    repeat (3) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    echo_en = 1'b1;
    test_full_run("err_run", 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got=%b exp=0", err);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      start = 1'b0;
    end
    n_cmp++;
    if ({rd_en, rd_addr, fm_sel} !== {1'b1, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_pos got rd_en,addr,sel=%b exp=%b", {rd_en, rd_addr, fm_sel}, {1'b1, 4'd9, 1'b1});
    end
    rst = 1'b1; echo_en = 1'b0; fm_valid_out = 1'b0;
    tick();
    rst = 1'b0; echo_hist = '0;
    n_cmp++;
    if ({rd_en, rd_addr, fm_valid_in, fm_sel, fm_start, busy, done, err} !== 11'h0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b exp=0", {rd_en, rd_addr, fm_valid_in, fm_sel, fm_start, busy, done, err});
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if ({rd_en, fm_valid_in, fm_sel, busy, err} !== 5'b0) begin
        n_fail++;
        $display("FAIL mid_quiet k=%0d got=%b exp=0", k, {rd_en, fm_valid_in, fm_sel, busy, err});
      end
    end
    echo_en = 1'b1;
    test_full_run("rerun", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_full_run("b2b_a", 1'b0, 1'b1);
    test_full_run("b2b_b", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run("run", 1'b0, 1'b0);
    test_hold();
    test_err_idle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
